raizing_vtimer_prog: RTL and testbench
======================================

Name: raizing_vtimer_prog

Overview:
Parametrised, runtime-programmable video timing generator. It is the successor to the fixed-constant sync generator in raizing_video.
- Produces pixel/line counters, blanking, sync, render-lookahead line and interrupt strobes for the GCU/sprite/tile pipelines.
- Timing comes from shadowed registers that the CPU/GCU interface can rewrite; changes apply only at frame boundaries.
- Also exports the sync window values for GCU vcount readback.

Parameters:
HW, 9, horizontal counter width
VW, 9, vertical counter width
H_LAST_D, 431, reset value of h_last (last hpos; line = h_last+1 pixels)
H_ACT_D, 320, reset value of h_act (visible pixels per line)
HS_START_D, 360, reset hsync start
HS_END_D, 379, reset hsync end (inclusive)
V_LAST_D, 262, reset value of v_last
V_ACT_D, 240, reset value of v_act (visible lines)
VS_START_D, 244, reset vsync start
VS_END_D, 249, reset vsync end (inclusive)
IRQ_LINE_D, 240, reset raster-interrupt line

Ports:
clk  in  1  system clock (96 MHz domain)
reset_n  in  1  asynchronous active-low reset
pxl_cen  in  1  pixel clock enable; counters advance only when high
cfg_we  in  1  config write strobe (one clk)
cfg_addr  in  3  register select (0 h_last, 1 h_act, 2 hs_start, 3 hs_end, 4 v_last, 5 v_act, 6 vs_start/vs_end packed, 7 irq_line)
cfg_data  in  18  write data; addr 6 uses [17:9]=vs_end, [8:0]=vs_start; other addresses use low HW/VW bits
hpos  out  HW  current pixel
vpos  out  VW  current line
vrender  out  VW  line being rendered (vpos+1, wraps)
lhbl  out  1  1 = horizontally visible
lvbl  out  1  1 = vertically visible
hsync  out  1  active-high hsync
vsync  out  1  active-high vsync
display_on  out  1  lhbl & lvbl
frame_start  out  1  one-clk strobe at hpos=0, vpos=0
vint  out  1  one-clk strobe at vblank entry
line_irq  out  1  one-clk strobe at raster compare
hs_start_o, hs_end_o  out  HW  active hsync window (GCU readback)
vs_start_o, vs_end_o  out  VW  active vsync window (GCU readback)

Behaviour:
- Reset (async, reset_n=0): hpos=0, vpos=0, vrender=1, lhbl=1, lvbl=1, hsync=0, vsync=0, display_on=1, all strobes 0. Active and pending banks load the *_D defaults.
- Counter advance, on clk with pxl_cen=1:
  - hpos := (hpos==h_last) ? 0 : hpos+1.
  - On hpos wrap, vpos := (vpos==v_last) ? 0 : vpos+1.
  - With pxl_cen=0 all outputs hold.
- Outputs are registered, updated in the same clk as the counters, and consistent with the new count:
  - lhbl = (hpos < h_act); lvbl = (vpos < v_act).
  - hsync = hs_start <= hpos <= hs_end; vsync = vs_start <= vpos <= vs_end.
  - vrender = (vpos==v_last) ? 0 : vpos+1.
- Strobes are exactly one clk wide, asserted in the clk the counters take the trigger value:
  - frame_start at (0,0).
  - vint at hpos=0, vpos=v_act.
  - line_irq at hpos=h_act, vpos=irq_line.
- Config handling:
  - cfg_we writes the pending bank at any time.
  - The active bank copies pending on the commit cycle: pxl_cen=1 with hpos==h_last and vpos==v_last. New values govern the frame starting at (0,0).
  - A write in the commit cycle is included in the commit (pending bypass).
- Degenerate values:
  - hs_start > hs_end gives no hsync; same for vsync.
  - h_act > h_last gives lhbl always 1; irq_line > v_last gives no line_irq.
  - The counters themselves never exceed h_last/v_last.
- Width rules: all compares are unsigned at HW/VW bits; cfg_data bits above those widths are ignored.
- Reset mid-frame: immediate return to reset values, pending writes discarded.

Decomposition:
- Package raizing_vtimer_pkg holds:
  - cfg_addr constants (REG_H_LAST..REG_IRQ_LINE);
  - the timing-bank struct typedef {h_last, h_act, hs_start, hs_end, v_last, v_act, vs_start, vs_end, irq_line};
  - the default bank constant.
- One sub-module, raizing_vtimer_axis, parametrised on width:
  - inputs: counter, advance, last, active-end and sync window;
  - outputs: pos, blank, sync and wrap.
  - Instantiated twice; the vertical instance advances on the horizontal wrap.

Test Plan:
- Reset defaults, pxl_cen every 4th clk for 2 frames -> hpos wraps 431->0, vpos 262->0. lhbl falls at hpos=320, hsync high hpos 360..379, vsync high vpos 244..249. Frame = 432*263*4 clk.
- Write h_last=383 mid-frame -> current frame keeps 432-pixel lines; after the commit cycle, lines are 384 pixels; frame_start pulses at the new (0,0).
- cfg_we with addr 7, data 100 on the exact commit cycle -> line_irq fires on the next frame at vpos=100, hpos=320.
- pxl_cen held low for 50 clk at hpos=200 -> all outputs frozen; strobes never stretched beyond one clk.
- reset_n low at vpos=130 asynchronously (not on clk edge) -> outputs go to reset values immediately; earlier pending h_last write lost.
- Set vs_start=250, vs_end=245 -> vsync never asserts; vint still pulses once per frame at vpos=240, hpos=0.

Source files
------------

// File: rtl/raizing_vtimer_pkg.sv
// Shared definitions for the programmable video timing generator:
// register map, timing-bank layout and power-on timing.
package raizing_vtimer_pkg;

  localparam int FW = 9;

  localparam logic [2:0] REG_H_LAST   = 3'd0;
  localparam logic [2:0] REG_H_ACT    = 3'd1;
  localparam logic [2:0] REG_HS_START = 3'd2;
  localparam logic [2:0] REG_HS_END   = 3'd3;
  localparam logic [2:0] REG_V_LAST   = 3'd4;
  localparam logic [2:0] REG_V_ACT    = 3'd5;
  localparam logic [2:0] REG_VS_WIN   = 3'd6;
  localparam logic [2:0] REG_IRQ_LINE = 3'd7;

  typedef struct packed {
    logic [FW-1:0] h_last;
    logic [FW-1:0] h_act;
    logic [FW-1:0] hs_start;
    logic [FW-1:0] hs_end;
    logic [FW-1:0] v_last;
    logic [FW-1:0] v_act;
    logic [FW-1:0] vs_start;
    logic [FW-1:0] vs_end;
    logic [FW-1:0] irq_line;
  } timing_bank_t;

  localparam timing_bank_t DEFAULT_BANK = '{
    h_last:   9'd431, h_act:  9'd320, hs_start: 9'd360, hs_end: 9'd379,
    v_last:   9'd262, v_act:  9'd240, vs_start: 9'd244, vs_end: 9'd249,
    irq_line: 9'd240
  };

endpackage

// File: rtl/raizing_vtimer_axis.sv
// One timing axis: next position, visible flag, sync window and wrap.
// Wrap depends only on the current count, never on the window inputs.
module raizing_vtimer_axis #(
  parameter int W = 9
) (
  input  logic [W-1:0] cnt,
  input  logic         adv,
  input  logic [W-1:0] last,
  input  logic [W-1:0] act_end,
  input  logic [W-1:0] sync_start,
  input  logic [W-1:0] sync_end,
  output logic [W-1:0] pos,
  output logic         vis,
  output logic         sync,
  output logic         wrap
);

  logic at_last;

  // >= keeps the counter bounded even if it were ever above last.
  assign at_last = (cnt >= last);
  assign wrap    = adv && at_last;
  assign pos     = !adv ? cnt : (at_last ? '0 : cnt + W'(1));
  assign vis     = (pos < act_end);
  assign sync    = (pos >= sync_start) && (pos <= sync_end);

endmodule

// File: rtl/raizing_vtimer_prog.sv
// Runtime-programmable video timing generator. The CPU writes a pending bank
// that becomes active at the frame boundary; all outputs are registered.
module raizing_vtimer_prog
  import raizing_vtimer_pkg::*;
#(
  parameter int HW         = 9,
  parameter int VW         = 9,
  parameter int H_LAST_D   = int'(DEFAULT_BANK.h_last),
  parameter int H_ACT_D    = int'(DEFAULT_BANK.h_act),
  parameter int HS_START_D = int'(DEFAULT_BANK.hs_start),
  parameter int HS_END_D   = int'(DEFAULT_BANK.hs_end),
  parameter int V_LAST_D   = int'(DEFAULT_BANK.v_last),
  parameter int V_ACT_D    = int'(DEFAULT_BANK.v_act),
  parameter int VS_START_D = int'(DEFAULT_BANK.vs_start),
  parameter int VS_END_D   = int'(DEFAULT_BANK.vs_end),
  parameter int IRQ_LINE_D = int'(DEFAULT_BANK.irq_line)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pxl_cen,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [17:0]   cfg_data,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic [VW-1:0] vrender,
  output logic          lhbl,
  output logic          lvbl,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          frame_start,
  output logic          vint,
  output logic          line_irq,
  output logic [HW-1:0] hs_start_o,
  output logic [HW-1:0] hs_end_o,
  output logic [VW-1:0] vs_start_o,
  output logic [VW-1:0] vs_end_o
);

  localparam timing_bank_t RST_BANK = '{
    h_last:   FW'(H_LAST_D),   h_act:  FW'(H_ACT_D),
    hs_start: FW'(HS_START_D), hs_end: FW'(HS_END_D),
    v_last:   FW'(V_LAST_D),   v_act:  FW'(V_ACT_D),
    vs_start: FW'(VS_START_D), vs_end: FW'(VS_END_D),
    irq_line: FW'(IRQ_LINE_D)
  };

  timing_bank_t pend_q, pend_d, act_q, act_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d, vrender_q, vrender_d;
  logic lhbl_q, lhbl_d, lvbl_q, lvbl_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic display_on_q, display_on_d, frame_start_q, frame_start_d;
  logic vint_q, vint_d, line_irq_q, line_irq_d;
  logic h_vis, h_sync, h_wrap, v_vis, v_sync, v_wrap;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    if (cfg_we) begin
      case (cfg_addr)
        REG_H_LAST:   pend_d.h_last   = FW'(cfg_data[HW-1:0]);
        REG_H_ACT:    pend_d.h_act    = FW'(cfg_data[HW-1:0]);
        REG_HS_START: pend_d.hs_start = FW'(cfg_data[HW-1:0]);
        REG_HS_END:   pend_d.hs_end   = FW'(cfg_data[HW-1:0]);
        REG_V_LAST:   pend_d.v_last   = FW'(cfg_data[VW-1:0]);
        REG_V_ACT:    pend_d.v_act    = FW'(cfg_data[VW-1:0]);
        REG_VS_WIN: begin
          pend_d.vs_start = FW'(cfg_data[VW-1:0]);
          pend_d.vs_end   = FW'(cfg_data[FW +: VW]);
        end
        REG_IRQ_LINE: pend_d.irq_line = FW'(cfg_data[VW-1:0]);
        default:      pend_d = pend_q;
      endcase
    end
  end

  // A vertical wrap is the last pixel of the frame: commit, including any
  // write landing in this same clk.
  always_comb begin
    act_d = v_wrap ? pend_d : act_q;
  end

  raizing_vtimer_axis #(.W(HW)) u_h_axis (
    .cnt        (hpos_q),
    .adv        (pxl_cen),
    .last       (act_q.h_last[HW-1:0]),
    .act_end    (act_d.h_act[HW-1:0]),
    .sync_start (act_d.hs_start[HW-1:0]),
    .sync_end   (act_d.hs_end[HW-1:0]),
    .pos        (hpos_d),
    .vis        (h_vis),
    .sync       (h_sync),
    .wrap       (h_wrap)
  );

  raizing_vtimer_axis #(.W(VW)) u_v_axis (
    .cnt        (vpos_q),
    .adv        (h_wrap),
    .last       (act_q.v_last[VW-1:0]),
    .act_end    (act_d.v_act[VW-1:0]),
    .sync_start (act_d.vs_start[VW-1:0]),
    .sync_end   (act_d.vs_end[VW-1:0]),
    .pos        (vpos_d),
    .vis        (v_vis),
    .sync       (v_sync),
    .wrap       (v_wrap)
  );

  // Decode against the new count and the bank that governs it.
  always_comb begin
    lhbl_d        = h_vis;
    lvbl_d        = v_vis;
    hsync_d       = h_sync;
    vsync_d       = v_sync;
    display_on_d  = h_vis & v_vis;
    vrender_d     = (vpos_d == act_d.v_last[VW-1:0]) ? '0 : vpos_d + VW'(1);
    frame_start_d = pxl_cen && (hpos_d == '0) && (vpos_d == '0);
    vint_d        = pxl_cen && (hpos_d == '0) && (vpos_d == act_d.v_act[VW-1:0]);
    line_irq_d    = pxl_cen && (hpos_d == act_d.h_act[HW-1:0])
                            && (vpos_d == act_d.irq_line[VW-1:0]);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= RST_BANK;
      act_q         <= RST_BANK;
      hpos_q        <= '0;
      vpos_q        <= '0;
      vrender_q     <= VW'(1);
      lhbl_q        <= 1'b1;
      lvbl_q        <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      display_on_q  <= 1'b1;
      frame_start_q <= 1'b0;
      vint_q        <= 1'b0;
      line_irq_q    <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      act_q         <= act_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      vrender_q     <= vrender_d;
      lhbl_q        <= lhbl_d;
      lvbl_q        <= lvbl_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
      vint_q        <= vint_d;
      line_irq_q    <= line_irq_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign vrender     = vrender_q;
  assign lhbl        = lhbl_q;
  assign lvbl        = lvbl_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign frame_start = frame_start_q;
  assign vint        = vint_q;
  assign line_irq    = line_irq_q;
  assign hs_start_o  = act_q.hs_start[HW-1:0];
  assign hs_end_o    = act_q.hs_end[HW-1:0];
  assign vs_start_o  = act_q.vs_start[VW-1:0];
  assign vs_end_o    = act_q.vs_end[VW-1:0];

endmodule

// File: tb/tb_raizing_vtimer_prog.sv
// Directed bench for raizing_vtimer_prog using a reduced frame (64x24) so
// several complete frames fit in a short run.
module tb_raizing_vtimer_prog;

  localparam int H_LAST = 63, H_ACT = 40, HS_S = 48, HS_E = 53;
  localparam int V_LAST = 23, V_ACT = 16, VS_S = 18, VS_E = 20, IRQ = 16;
  localparam logic [34:0] RESET_VEC =
    {9'd0, 9'd0, 9'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};

  logic        clk = 1'b0, reset_n = 1'b0, pxl_cen = 1'b0, cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [17:0] cfg_data = '0;
  logic [8:0]  hpos, vpos, vrender, hs_start_o, hs_end_o, vs_start_o, vs_end_o;
  logic        lhbl, lvbl, hsync, vsync, display_on, frame_start, vint, line_irq;

  int n_cmp = 0, n_bad = 0, cyc = 0, cen_div = 1;
  int mh, mv;
  int act[9], pend[9];
  int fs_cnt, vint_cnt, vs_cnt, lhbl0_cnt, li_cnt, fs_last_cyc, fs_period;

  raizing_vtimer_prog #(
    .HW(9), .VW(9), .H_LAST_D(H_LAST), .H_ACT_D(H_ACT), .HS_START_D(HS_S),
    .HS_END_D(HS_E), .V_LAST_D(V_LAST), .V_ACT_D(V_ACT), .VS_START_D(VS_S),
    .VS_END_D(VS_E), .IRQ_LINE_D(IRQ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pxl_cen(pxl_cen), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .hpos(hpos), .vpos(vpos),
    .vrender(vrender), .lhbl(lhbl), .lvbl(lvbl), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .frame_start(frame_start), .vint(vint),
    .line_irq(line_irq), .hs_start_o(hs_start_o), .hs_end_o(hs_end_o),
    .vs_start_o(vs_start_o), .vs_end_o(vs_end_o)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] obs_vec();
    return {hpos, vpos, vrender, lhbl, lvbl, hsync, vsync, display_on,
            frame_start, vint, line_irq};
  endfunction

  // Expected outputs for the model position under the model's active bank.
  function automatic logic [34:0] exp_vec(input bit stb);
    logic [8:0] vr;
    logic lh, lv, hs, vs, fs, vi, li;
    vr = (mv == act[4]) ? 9'd0 : 9'(mv + 1);
    lh = (mh < act[1]);
    lv = (mv < act[5]);
    hs = (mh >= act[2]) && (mh <= act[3]);
    vs = (mv >= act[6]) && (mv <= act[7]);
    fs = stb && (mh == 0) && (mv == 0);
    vi = stb && (mh == 0) && (mv == act[5]);
    li = stb && (mh == act[1]) && (mv == act[8]);
    return {9'(mh), 9'(mv), vr, lh, lv, hs, vs, lh & lv, fs, vi, li};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    act = '{H_LAST, H_ACT, HS_S, HS_E, V_LAST, V_ACT, VS_S, VS_E, IRQ};
    pend = act;
  endtask

  task automatic model_write(input int a, input logic [17:0] d);
    case (a)
      6: begin pend[6] = int'(d[8:0]); pend[7] = int'(d[17:9]); end
      7: pend[8] = int'(d[8:0]);
      default: pend[a] = int'(d[8:0]);
    endcase
  endtask

  task automatic model_adv();
    bit com;
    com = (mh == act[0]) && (mv == act[4]);
    if (mh == act[0]) begin
      mh = 0;
      mv = (mv == act[4]) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (com) act = pend;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    fs_cnt = 0; vint_cnt = 0; vs_cnt = 0; lhbl0_cnt = 0; li_cnt = 0;
    fs_last_cyc = -1; fs_period = 0;
  endtask

  // One pixel advance (after cen_div-1 idle clks), optionally writing config
  // in the advancing clk.
  task automatic step_pix(input bit wr, input logic [2:0] a,
                          input logic [17:0] d, input string tag);
    for (int i = 1; i < cen_div; i++) begin
      pxl_cen = 1'b0;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        n_bad++;
        $display("FAIL %s idle hold: got %h expected %h", tag, obs_vec(), exp_vec(1'b0));
      end
    end
    pxl_cen = 1'b1; cfg_we = wr; cfg_addr = a; cfg_data = d;
    tick();
    pxl_cen = 1'b0; cfg_we = 1'b0;
    if (wr) model_write(int'(a), d);
    model_adv();
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1)) begin
      n_bad++;
      $display("FAIL %s at (%0d,%0d): got %h expected %h", tag, mh, mv, obs_vec(), exp_vec(1'b1));
    end
    if (frame_start) begin
      fs_cnt++;
      if (fs_last_cyc >= 0) fs_period = cyc - fs_last_cyc;
      fs_last_cyc = cyc;
    end
    if (vint) vint_cnt++;
    if (vsync) vs_cnt++;
    if (!lhbl) lhbl0_cnt++;
    if (line_irq) li_cnt++;
  endtask

  task automatic run_pix(input int n, input string tag);
    for (int i = 0; i < n; i++) step_pix(1'b0, 3'd0, 18'd0, tag);
  endtask

  task automatic cfg_write_idle(input logic [2:0] a, input logic [17:0] d);
    pxl_cen = 1'b0; cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    model_write(int'(a), d);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      n_bad++;
      $display("FAIL cfg_write hold: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic check_pos(input string tag, input logic [8:0] eh, input logic [8:0] ev);
    n_cmp++;
    if ({hpos, vpos} !== {eh, ev}) begin
      n_bad++;
      $display("FAIL %s pos: got (%0d,%0d) expected (%0d,%0d)", tag, hpos, vpos, eh, ev);
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0; pxl_cen = 1'b0; cfg_we = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset outputs: got %h expected %h", obs_vec(), RESET_VEC);
    end
    n_cmp++;
    if ({hs_start_o, hs_end_o, vs_start_o, vs_end_o} !== {9'd48, 9'd53, 9'd18, 9'd20}) begin
      n_bad++;
      $display("FAIL reset windows: got %0d %0d %0d %0d expected 48 53 18 20",
               hs_start_o, hs_end_o, vs_start_o, vs_end_o);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset release: got %h expected %h", obs_vec(), RESET_VEC);
    end
  endtask

  task automatic test_frames();
    cen_div = 4;
    clear_stats();
    run_pix(2 * 1536, "frames");
    n_cmp++;
    if (fs_cnt !== 2) begin n_bad++; $display("FAIL frames frame_start count: got %0d expected 2", fs_cnt); end
    n_cmp++;
    if (fs_period !== 6144) begin n_bad++; $display("FAIL frames period: got %0d expected 6144", fs_period); end
    n_cmp++;
    if (vint_cnt !== 2) begin n_bad++; $display("FAIL frames vint count: got %0d expected 2", vint_cnt); end
    n_cmp++;
    if (vs_cnt !== 384) begin n_bad++; $display("FAIL frames vsync pixels: got %0d expected 384", vs_cnt); end
    n_cmp++;
    if (lhbl0_cnt !== 1152) begin n_bad++; $display("FAIL frames hblank pixels: got %0d expected 1152", lhbl0_cnt); end
    check_pos("frames end", 9'd0, 9'd0);
  endtask

  task automatic test_h_last_change();
    cen_div = 1;
    run_pix(500, "hlast pre");
    check_pos("hlast mid", 9'd52, 9'd7);
    cfg_write_idle(3'd0, 18'd47);
    run_pix(1536 - 500 - 1, "hlast old frame");
    check_pos("hlast last pixel", 9'd63, 9'd23);
    run_pix(1, "hlast commit");
    n_cmp++;
    if (frame_start !== 1'b1) begin n_bad++; $display("FAIL hlast frame_start: got %b expected 1", frame_start); end
    run_pix(47, "hlast new line");
    check_pos("hlast new last", 9'd47, 9'd0);
    run_pix(1, "hlast new wrap");
    check_pos("hlast new wrap", 9'd0, 9'd1);
  endtask

  task automatic test_commit_bypass();
    run_pix(1152 - 48 - 1, "bypass approach");
    check_pos("bypass commit pos", 9'd47, 9'd23);
    step_pix(1'b1, 3'd7, {9'h1AB, 9'd10}, "bypass commit");
    run_pix(520, "bypass irq");
    n_cmp++;
    if ({line_irq, hpos, vpos} !== {1'b1, 9'd40, 9'd10}) begin
      n_bad++;
      $display("FAIL bypass line_irq: got %b at (%0d,%0d) expected 1 at (40,10)", line_irq, hpos, vpos);
    end
  endtask

  task automatic test_cen_hold();
    logic [34:0] held;
    held = {9'd40, 9'd10, 9'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
    pxl_cen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== held) begin
        n_bad++;
        $display("FAIL cen hold clk %0d: got %h expected %h", i, obs_vec(), held);
      end
    end
    run_pix(1, "cen resume");
    check_pos("cen resume", 9'd41, 9'd10);
  endtask

  task automatic test_degenerate();
    cfg_write_idle(3'd6, {9'd19, 9'd22});
    cfg_write_idle(3'd1, 18'd60);
    run_pix(1152 - (10 * 48 + 41), "degen approach");
    check_pos("degen frame start", 9'd0, 9'd0);
    clear_stats();
    run_pix(1152, "degen frame");
    n_cmp++;
    if (vs_cnt !== 0) begin n_bad++; $display("FAIL degen vsync pixels: got %0d expected 0", vs_cnt); end
    n_cmp++;
    if (vint_cnt !== 1) begin n_bad++; $display("FAIL degen vint count: got %0d expected 1", vint_cnt); end
    n_cmp++;
    if (lhbl0_cnt !== 0) begin n_bad++; $display("FAIL degen hblank pixels: got %0d expected 0", lhbl0_cnt); end
    n_cmp++;
    if (li_cnt !== 0) begin n_bad++; $display("FAIL degen line_irq count: got %0d expected 0", li_cnt); end
  endtask

  task automatic test_reset_midframe();
    cfg_write_idle(3'd0, 18'd31);
    run_pix(13 * 48 + 5, "rst approach");
    check_pos("rst approach", 9'd5, 9'd13);
    pxl_cen = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL async reset: got %h expected %h", obs_vec(), RESET_VEC);
    end
    n_cmp++;
    if ({hs_start_o, hs_end_o, vs_start_o, vs_end_o} !== {9'd48, 9'd53, 9'd18, 9'd20}) begin
      n_bad++;
      $display("FAIL async reset windows: got %0d %0d %0d %0d expected 48 53 18 20",
               hs_start_o, hs_end_o, vs_start_o, vs_end_o);
    end
    tick();
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset held: got %h expected %h", obs_vec(), RESET_VEC);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    pxl_cen = 1'b0;
    model_reset();
    run_pix(1536, "rst frame");
    run_pix(32, "rst pending lost");
    check_pos("rst pending lost", 9'd32, 9'd0);
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_frames();
    test_h_last_change();
    test_commit_bypass();
    test_cen_hold();
    test_degenerate();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
